// File: rtl/hazard_control_unit.sv
// ID/EX hazard unit: multi-cycle load-use stalls, fixed-latency multiply tracking, branch flush.
// Define HAZARD_STATS_EN to add saturating stall/flush/mul-stall event counters.
module hazard_control_unit #(
    parameter int unsigned                         OP_W       = 4,
    parameter int unsigned                         RADDR_W    = 4,
    parameter int unsigned                         NUM_RPORTS = 2,
    parameter logic [NUM_RPORTS*(2**OP_W)-1:0]     USE_MASK   = {16'h060F, 16'h03FF},
    parameter int unsigned                         LOAD_LAT   = 1,
    parameter logic [OP_W-1:0]                     MUL_OP     = 4'd11,
    parameter int unsigned                         MUL_LAT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [OP_W-1:0]               id_opcode,
    input  logic [RADDR_W-1:0]            id_waddr,
    input  logic [NUM_RPORTS*RADDR_W-1:0] id_raddr,
    input  logic [RADDR_W-1:0]            ex_waddr,
    input  logic                          ex_wdata_sc2,
    input  logic                          ex_rfwen,
    input  logic                          ex_branch_taken,
    output logic                          stall,
    output logic                          bubble,
    output logic                          flush_ifid,
    output logic                          mul_start,
    output logic                          mul_busy,
    output logic [1:0]                    state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                   stat_stall_cycles,
    output logic [31:0]                   stat_flushes,
    output logic [31:0]                   stat_mul_stalls
`endif
);

    localparam int unsigned NOPS = 2**OP_W;
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_LD_WAIT = 2'd1;

    logic [1:0]            r_state, w_state_nxt;
    logic [2:0]            r_ld_cnt, w_ld_cnt_nxt;
    logic                  r_mul_busy;
    logic [3:0]            r_mul_cnt;
    logic [RADDR_W-1:0]    r_mul_dst;

    logic [NUM_RPORTS-1:0] w_use;
    logic                  w_ld_match, w_mul_match;
    logic                  w_load_hit, w_mul_hit;

    always_comb begin
        w_use       = '0;
        w_ld_match  = 1'b0;
        w_mul_match = 1'b0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            w_use[p] = USE_MASK[p*NOPS + int'(id_opcode)] &&
                       (id_raddr[p*RADDR_W +: RADDR_W] != '0);
            if (w_use[p] && (id_raddr[p*RADDR_W +: RADDR_W] == ex_waddr)) w_ld_match = 1'b1;
            if (w_use[p] && (id_raddr[p*RADDR_W +: RADDR_W] == r_mul_dst)) w_mul_match = 1'b1;
        end
    end

    assign w_load_hit = ex_wdata_sc2 && ex_rfwen && (ex_waddr != '0) && w_ld_match;
    assign w_mul_hit  = r_mul_busy && ((id_opcode == MUL_OP) || w_mul_match);

    // Taken branch wins over any stall: the held instruction is on the wrong path anyway.
    always_comb begin
        flush_ifid = !rst && ex_branch_taken;
        stall      = !rst && !ex_branch_taken &&
                     ((r_state == ST_LD_WAIT) || w_load_hit || w_mul_hit);
        bubble     = stall || flush_ifid;
        mul_start  = !rst && (id_opcode == MUL_OP) && !stall && !flush_ifid;
    end

    assign state    = r_state;
    assign mul_busy = r_mul_busy;

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_cnt_nxt = r_ld_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!ex_branch_taken && w_load_hit && (LOAD_LAT > 1)) begin
                    w_state_nxt  = ST_LD_WAIT;
                    w_ld_cnt_nxt = 3'(LOAD_LAT - 1);
                end
            end
            ST_LD_WAIT: begin
                if (ex_branch_taken || (r_ld_cnt <= 3'd1)) begin
                    w_state_nxt  = ST_IDLE;
                    w_ld_cnt_nxt = 3'd0;
                end else begin
                    w_ld_cnt_nxt = r_ld_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_ld_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ld_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_ld_cnt <= w_ld_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_busy <= 1'b0;
            r_mul_cnt  <= 4'd0;
            r_mul_dst  <= '0;
        end else if (mul_start) begin
            r_mul_busy <= 1'b1;
            r_mul_cnt  <= 4'(MUL_LAT - 1);
            r_mul_dst  <= id_waddr;
        end else if (r_mul_busy) begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
            if (r_mul_cnt == 4'd1) r_mul_busy <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stat_stall, r_stat_flush, r_stat_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
            r_stat_flush <= '0;
            r_stat_mul   <= '0;
        end else begin
            if (stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
            if (flush_ifid && (r_stat_flush != '1)) r_stat_flush <= r_stat_flush + 32'd1;
            if (stall && w_mul_hit && (r_stat_mul != '1)) r_stat_mul <= r_stat_mul + 32'd1;
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_flushes      = r_stat_flush;
    assign stat_mul_stalls   = r_stat_mul;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with LOAD_LAT=1, one with LOAD_LAT=3.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] id_opcode;
    logic [3:0] id_waddr;
    logic [7:0] id_raddr;
    logic [3:0] ex_waddr;
    logic       ex_wdata_sc2;
    logic       ex_rfwen;
    logic       ex_branch_taken;

    logic       a_stall, a_bubble, a_flush, a_mul_start, a_mul_busy;
    logic [1:0] a_state;
    logic       b_stall, b_bubble, b_flush, b_mul_start, b_mul_busy;
    logic [1:0] b_state;
`ifdef HAZARD_STATS_EN
    logic [31:0] a_st_stall, a_st_flush, a_st_mul;
    logic [31:0] b_st_stall, b_st_flush, b_st_mul;
`endif

    int n_vec = 0;
    int n_err = 0;

    hazard_control_unit #(.LOAD_LAT(1)) u_dut_l1 (
        .clk             (clk),
        .rst             (rst),
        .id_opcode       (id_opcode),
        .id_waddr        (id_waddr),
        .id_raddr        (id_raddr),
        .ex_waddr        (ex_waddr),
        .ex_wdata_sc2    (ex_wdata_sc2),
        .ex_rfwen        (ex_rfwen),
        .ex_branch_taken (ex_branch_taken),
        .stall           (a_stall),
        .bubble          (a_bubble),
        .flush_ifid      (a_flush),
        .mul_start       (a_mul_start),
        .mul_busy        (a_mul_busy),
        .state           (a_state)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stall_cycles (a_st_stall),
        .stat_flushes      (a_st_flush),
        .stat_mul_stalls   (a_st_mul)
`endif
    );

    hazard_control_unit #(.LOAD_LAT(3)) u_dut_l3 (
        .clk             (clk),
        .rst             (rst),
        .id_opcode       (id_opcode),
        .id_waddr        (id_waddr),
        .id_raddr        (id_raddr),
        .ex_waddr        (ex_waddr),
        .ex_wdata_sc2    (ex_wdata_sc2),
        .ex_rfwen        (ex_rfwen),
        .ex_branch_taken (ex_branch_taken),
        .stall           (b_stall),
        .bubble          (b_bubble),
        .flush_ifid      (b_flush),
        .mul_start       (b_mul_start),
        .mul_busy        (b_mul_busy),
        .state           (b_state)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stall_cycles (b_st_stall),
        .stat_flushes      (b_st_flush),
        .stat_mul_stalls   (b_st_mul)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [3:0] wa, input logic [3:0] r1,
                          input logic [3:0] r0, input logic [3:0] exwa, input logic sc2,
                          input logic wen, input logic br);
        id_opcode       = op;
        id_waddr        = wa;
        id_raddr        = {r1, r0};
        ex_waddr        = exwa;
        ex_wdata_sc2    = sc2;
        ex_rfwen        = wen;
        ex_branch_taken = br;
        #2;
    endtask

    task automatic do_reset();
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        // Hazard present on the inputs while reset is held: outputs must stay quiet.
        set_in(4'd2, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1);
        chk("rst_state", {30'd0, b_state}, 32'd0);
        chk("rst_mul_busy", {31'd0, b_mul_busy}, 32'd0);
        chk("rst_stall", {31'd0, b_stall}, 32'd0);
        chk("rst_flush", {31'd0, b_flush}, 32'd0);
        chk("rst_bubble", {31'd0, a_bubble}, 32'd0);
        do_reset();

        // LOAD_LAT=1: single stall cycle, state never leaves IDLE
        tick();
        set_in(4'd2, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("l1_stall", {31'd0, a_stall}, 32'd1);
        chk("l1_bubble", {31'd0, a_bubble}, 32'd1);
        chk("l1_state", {30'd0, a_state}, 32'd0);
        tick();
        set_in(4'd2, 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("l1_release", {31'd0, a_stall}, 32'd0);
        chk("l1_state_after", {30'd0, a_state}, 32'd0);

        // LOAD_LAT=3 on port 1, opcode 10
        do_reset();
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("l3_c0_stall", {31'd0, b_stall}, 32'd1);
        chk("l3_c0_state", {30'd0, b_state}, 32'd0);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("l3_c1_stall", {31'd0, b_stall}, 32'd1);
        chk("l3_c1_state", {30'd0, b_state}, 32'd1);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("l3_c2_stall", {31'd0, b_stall}, 32'd1);
        chk("l3_c2_bubble", {31'd0, b_bubble}, 32'd1);
        chk("l3_c2_state", {30'd0, b_state}, 32'd1);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("l3_c3_stall", {31'd0, b_stall}, 32'd0);
        chk("l3_c3_state", {30'd0, b_state}, 32'd0);

        // Masked, r0 and non-load cases
        set_in(4'd4, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("mask_clear", {31'd0, b_stall}, 32'd0);
        set_in(4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("load_r0", {31'd0, b_stall}, 32'd0);
        set_in(4'd2, 4'd0, 4'd0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
        chk("non_load", {31'd0, b_stall}, 32'd0);
        set_in(4'd2, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("port1_op2", {31'd0, a_stall}, 32'd1);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Multiply to r7 followed by a dependent read
        do_reset();
        tick();
        set_in(4'd11, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mul_start", {31'd0, a_mul_start}, 32'd1);
        chk("mul_no_stall", {31'd0, a_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_in(4'd2, 4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("mul_dep_stall%0d", i), {31'd0, a_stall}, 32'd1);
            chk($sformatf("mul_busy%0d", i), {31'd0, a_mul_busy}, 32'd1);
            chk($sformatf("mul_start_low%0d", i), {31'd0, a_mul_start}, 32'd0);
        end
        tick();
        set_in(4'd2, 4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mul_done_stall", {31'd0, a_stall}, 32'd0);
        chk("mul_done_busy", {31'd0, a_mul_busy}, 32'd0);

        // Independent read and a second multiply while busy
        do_reset();
        tick();
        set_in(4'd11, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(4'd2, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mul_indep", {31'd0, a_stall}, 32'd0);
        chk("mul_indep_busy", {31'd0, a_mul_busy}, 32'd1);
        set_in(4'd11, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mul_reissue_stall", {31'd0, a_stall}, 32'd1);
        chk("mul_reissue_start", {31'd0, a_mul_start}, 32'd0);
        set_in(4'd11, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("mul_branch_flush", {31'd0, a_flush}, 32'd1);
        chk("mul_branch_nostall", {31'd0, a_stall}, 32'd0);
        chk("mul_branch_nostart", {31'd0, a_mul_start}, 32'd0);

        // Branch in the second LOAD_LAT=3 stall cycle
        do_reset();
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("br_c0_stall", {31'd0, b_stall}, 32'd1);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("br_state", {30'd0, b_state}, 32'd1);
        chk("br_flush", {31'd0, b_flush}, 32'd1);
        chk("br_bubble", {31'd0, b_bubble}, 32'd1);
        chk("br_stall", {31'd0, b_stall}, 32'd0);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("br_after_state", {30'd0, b_state}, 32'd0);
        chk("br_after_stall", {31'd0, b_stall}, 32'd0);
        chk("br_after_flush", {31'd0, b_flush}, 32'd0);

        // Async reset during LD_WAIT with a multiply pending
        do_reset();
        tick();
        set_in(4'd11, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rs_mul_start", {31'd0, b_mul_start}, 32'd1);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("rs_load_stall", {31'd0, b_stall}, 32'd1);
        chk("rs_busy_pre", {31'd0, b_mul_busy}, 32'd1);
        tick();
        set_in(4'd10, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rs_ldwait", {30'd0, b_state}, 32'd1);
        chk("rs_busy_mid", {31'd0, b_mul_busy}, 32'd1);
`ifdef HAZARD_STATS_EN
        chk("rs_stat_stall_pre", b_st_stall, 32'd1);
`endif
        rst = 1'b1;
        #1;
        chk("rs_state", {30'd0, b_state}, 32'd0);
        chk("rs_busy", {31'd0, b_mul_busy}, 32'd0);
        chk("rs_stall", {31'd0, b_stall}, 32'd0);
        chk("rs_bubble", {31'd0, b_bubble}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("rs_stat_stall", b_st_stall, 32'd0);
        chk("rs_stat_flush", b_st_flush, 32'd0);
        chk("rs_stat_mul", b_st_mul, 32'd0);
`endif
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
